// File: rtl/comp2sm_serial.sv
// Bit-serial two's-complement to sign-magnitude converter for two channels (A, B), LSB first.
// Optional build macro SATURATE_EN: the most-negative input saturates to {1, all ones} instead of {1, zeros}.
module comp2sm_serial #(
  parameter int bitNumber = 8
) (
  input  logic                 clk1,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [bitNumber-1:0] A,
  input  logic [bitNumber-1:0] B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [bitNumber-1:0] Aout,
  output logic [bitNumber-1:0] Bout,
  output logic                 Aovf,
  output logic                 Bovf
);

  localparam int CW = (bitNumber > 2) ? $clog2(bitNumber - 1) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(bitNumber - 2);
  localparam logic [bitNumber-1:0] MOST_NEG = {1'b1, {(bitNumber-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state;
  logic [bitNumber-1:0] a_reg;
  logic [bitNumber-1:0] b_reg;
  logic [CW-1:0]        cnt;
  logic                 seen_a;
  logic                 seen_b;
  logic                 a_bit;
  logic                 b_bit;

  assign in_ready = (state == IDLE);

  // Negative words copy bits up to and including the first 1, then invert the rest.
  always_comb begin
    a_bit = a_reg[cnt] ^ (a_reg[bitNumber-1] & seen_a);
    b_bit = b_reg[cnt] ^ (b_reg[bitNumber-1] & seen_b);
`ifdef SATURATE_EN
    a_bit = a_bit | Aovf;
    b_bit = b_bit | Bovf;
`endif
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      cnt       <= '0;
      seen_a    <= 1'b0;
      seen_b    <= 1'b0;
      Aout      <= '0;
      Bout      <= '0;
      Aovf      <= 1'b0;
      Bovf      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= A;
            b_reg  <= B;
            cnt    <= '0;
            seen_a <= 1'b0;
            seen_b <= 1'b0;
            Aout   <= {A[bitNumber-1], {(bitNumber-1){1'b0}}};
            Bout   <= {B[bitNumber-1], {(bitNumber-1){1'b0}}};
            Aovf   <= (A == MOST_NEG);
            Bovf   <= (B == MOST_NEG);
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          Aout[cnt] <= a_bit;
          Bout[cnt] <= b_bit;
          seen_a    <= seen_a | a_reg[cnt];
          seen_b    <= seen_b | b_reg[cnt];
          cnt       <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comp2sm_serial.sv
// Directed bench for comp2sm_serial: 8-bit instance with a scoreboard model, plus a 4-bit instance.
module tb_comp2sm_serial;

  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk1 = ~clk1;

  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       in_ready, out_valid, aovf, bovf;
  logic [7:0] aout, bout;

  logic       in_valid4 = 1'b0, out_ready4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       in_ready4, out_valid4, aovf4, bovf4;
  logic [3:0] aout4, bout4;

  int passed = 0;
  int total = 0;
  int cycle = 0;

`ifdef SATURATE_EN
  localparam logic [7:0] MOST_NEG_EXP = 8'hFF;
`else
  localparam logic [7:0] MOST_NEG_EXP = 8'h80;
`endif

  comp2sm_serial #(.bitNumber(8)) dut (
    .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready),
    .Aout(aout), .Bout(bout), .Aovf(aovf), .Bovf(bovf)
  );

  comp2sm_serial #(.bitNumber(4)) dut4 (
    .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .A(a4), .B(b4), .out_valid(out_valid4), .out_ready(out_ready4),
    .Aout(aout4), .Bout(bout4), .Aovf(aovf4), .Bovf(bovf4)
  );

  always @(posedge clk1) cycle++;

  // True-form value of a w-bit two's-complement word, computed arithmetically.
  function automatic int model_sm(int w, int v);
    int mag;
    if (((v >> (w - 1)) & 1) == 0) return v;
    mag = (1 << w) - v;
    if (mag == (1 << (w - 1))) begin
`ifdef SATURATE_EN
      return (1 << w) - 1;
`else
      return 1 << (w - 1);
`endif
    end
    return (1 << (w - 1)) | mag;
  endfunction

  function automatic logic model_ovf(int w, int v);
    return v == (1 << (w - 1));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  typedef struct {
    logic [7:0] a_sm;
    logic [7:0] b_sm;
    logic       a_ovf;
    logic       b_ovf;
    int         acc_cyc;
  } exp_t;

  exp_t sb[$];
  logic prev_valid = 1'b0;

  // Scoreboard: expectations are queued at acceptance and compared every cycle out_valid is high.
  always @(negedge clk1) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("reset_aout", {24'd0, aout}, 32'd0);
      checkOutput("reset_bout", {24'd0, bout}, 32'd0);
      checkOutput("reset_ovf", {30'd0, aovf, bovf}, 32'd0);
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          checkOutput("sb_aout", {24'd0, aout}, {24'd0, sb[0].a_sm});
          checkOutput("sb_bout", {24'd0, bout}, {24'd0, sb[0].b_sm});
          checkOutput("sb_aovf", {31'd0, aovf}, {31'd0, sb[0].a_ovf});
          checkOutput("sb_bovf", {31'd0, bovf}, {31'd0, sb[0].b_ovf});
          checkOutput("sb_in_ready_busy", {31'd0, in_ready}, 32'd0);
          if (!prev_valid) checkOutput("sb_latency", cycle - sb[0].acc_cyc, 32'd7);
          if (out_ready) void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        e.a_sm    = 8'(model_sm(8, int'(a)));
        e.b_sm    = 8'(model_sm(8, int'(b)));
        e.a_ovf   = model_ovf(8, int'(a));
        e.b_ovf   = model_ovf(8, int'(b));
        e.acc_cyc = cycle + 1;
        sb.push_back(e);
      end
      prev_valid = out_valid;
    end
  end

  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv);
    int n = 0;
    @(posedge clk1); #1;
    while (!in_ready && n < 50) begin
      @(posedge clk1); #1;
      n++;
    end
    checkOutput("in_ready_wait", {31'd0, in_ready}, 32'd1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk1); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitOutput();
    int n = 0;
    @(negedge clk1);
    while (!out_valid && n < 50) begin
      @(negedge clk1);
      n++;
    end
    checkOutput("out_valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic releaseOutput();
    @(posedge clk1); #1;
    out_ready = 1'b1;
    @(posedge clk1); #1;
    out_ready = 1'b0;
  endtask

  task automatic runWord(input string name, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ea, input logic [7:0] eb, input logic eao, input logic ebo);
    applyStimulus(av, bv);
    waitOutput();
    checkOutput({name, "_aout"}, {24'd0, aout}, {24'd0, ea});
    checkOutput({name, "_bout"}, {24'd0, bout}, {24'd0, eb});
    checkOutput({name, "_ovf"}, {30'd0, aovf, bovf}, {30'd0, eao, ebo});
    releaseOutput();
  endtask

  initial begin
    int n;
    int start;
    repeat (2) @(posedge clk1);
    #1 rst_n = 1'b1;
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);

    runWord("t1", 8'h05, 8'hFB, 8'h05, 8'h85, 1'b0, 1'b0);
    runWord("t2a", 8'hFF, 8'h81, 8'h81, 8'hFF, 1'b0, 1'b0);
    runWord("t2b", 8'h00, 8'h7F, 8'h00, 8'h7F, 1'b0, 1'b0);
    runWord("t3", 8'h80, 8'h80, MOST_NEG_EXP, MOST_NEG_EXP, 1'b1, 1'b1);
    runWord("t3b", 8'hFE, 8'h40, 8'h82, 8'h40, 1'b0, 1'b0);

    // Backpressure: hold DONE and try to sneak in another word.
    applyStimulus(8'h12, 8'hF0);
    waitOutput();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk1); #1;
      in_valid = (i == 2);
      a = 8'h33;
      b = 8'h44;
      @(negedge clk1);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_aout", {24'd0, aout}, 32'h12);
      checkOutput("bp_bout", {24'd0, bout}, 32'h90);
    end
    @(posedge clk1); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk1); #1;
    out_ready = 1'b0;
    checkOutput("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("bp_result_hold", {24'd0, aout}, 32'h12);

    // Reset in the middle of a conversion.
    applyStimulus(8'hC3, 8'h05);
    repeat (3) @(posedge clk1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_aout", {24'd0, aout}, 32'd0);
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk1);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk1);
      checkOutput("midrst_no_valid", {31'd0, out_valid}, 32'd0);
    end
    runWord("t5", 8'hC3, 8'h05, 8'hBD, 8'h05, 1'b0, 1'b0);

    // Narrow instance: latency is bitNumber-1 = 3 cycles.
    @(posedge clk1); #1;
    checkOutput("w4_in_ready", {31'd0, in_ready4}, 32'd1);
    a4 = 4'hA;
    b4 = 4'h3;
    in_valid4 = 1'b1;
    @(posedge clk1); #1;
    start = cycle;
    in_valid4 = 1'b0;
    n = 0;
    @(negedge clk1);
    while (!out_valid4 && n < 20) begin
      @(negedge clk1);
      n++;
    end
    checkOutput("w4_out_valid", {31'd0, out_valid4}, 32'd1);
    checkOutput("w4_latency", cycle - start, 32'd3);
    checkOutput("w4_aout", {28'd0, aout4}, 32'hE);
    checkOutput("w4_bout", {28'd0, bout4}, 32'h3);
    checkOutput("w4_ovf", {30'd0, aovf4, bovf4}, 32'd0);
    checkOutput("w4_model_a", {28'd0, aout4}, 32'(model_sm(4, 'hA)));
    @(posedge clk1); #1;
    out_ready4 = 1'b1;
    @(posedge clk1); #1;
    out_ready4 = 1'b0;
    checkOutput("w4_release", {31'd0, in_ready4}, 32'd1);

    repeat (3) @(posedge clk1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/comp2sm_serial.md
Name: comp2sm_serial

Overview:
Bit-serial two's-complement to sign-magnitude (true form) converter. It is the inverse of the team's combinational sign-magnitude-to-complement block. Two channels (A, B) are converted together, one bit per clock, LSB first, with a valid/ready handshake on both input and output. It sits on the datapath where complement-coded results are converted back to true form for display or serial output.

Parameters:
bitNumber, 8, word width including sign bit; legal range >= 2

Ports:
clk1  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  A/B present a word to convert
in_ready  output  1  block can accept a word (high only in IDLE)
A  input  bitNumber  channel A operand, two's complement
B  input  bitNumber  channel B operand, two's complement
out_valid  output  1  Aout/Bout/Aovf/Bovf valid
out_ready  input  1  consumer takes the result
Aout  output  bitNumber  channel A result, sign-magnitude
Bout  output  bitNumber  channel B result, sign-magnitude
Aovf  output  1  A was the most-negative value (no true-form representation)
Bovf  output  1  B was the most-negative value

Behaviour:
- One clock: clk1. Reset is asynchronous and active-low on rst_n. rst_n low -> state IDLE; Aout=Bout=0, Aovf=Bovf=0, out_valid=0, bit counter=0, seen-one flags=0. in_ready=1 as soon as state is IDLE.
- FSM states:
  - IDLE: in_ready=1. in_valid & in_ready latches A and B, clears the counter and both seen-one flags, copies each sign bit into result MSB, then goes to SHIFT.
  - SHIFT: on each clock, processes bit i, i = counter = 0..bitNumber-2, per channel.
    - Sign 0: out[i] = in[i].
    - Sign 1: out[i] = in[i] ^ seen; then seen = seen | in[i]. This is copy-through-first-1, invert-above.
    - When i = bitNumber-2, go to DONE.
  - DONE: out_valid=1. Aout, Bout, Aovf and Bovf are held stable. out_valid & out_ready -> IDLE on the next edge.
- Latency: input accepted at edge t0 -> out_valid high after edge t0+bitNumber-1 (7 cycles for 8 bits). Minimum period between acceptances is bitNumber+1 cycles.
- in_ready=0 in SHIFT and DONE. in_valid is ignored there and no operand is captured.
- Overflow: xovf=1 iff input = {1, all zeros}. Computed at acceptance, registered, held with the result.
- Zero input -> zero output, xovf=0. Positive inputs pass through unchanged.
- Results hold their last value after the output handshake until the next acceptance overwrites them.
- rst_n asserted mid-SHIFT or in DONE: immediate return to reset values. The in-flight word is discarded and no out_valid is produced.
- out_ready held low in DONE: stays in DONE indefinitely, outputs stable.

Optional Feature:
SATURATE_EN
- Undefined: most-negative input yields the natural algorithm result {1, zeros} ("negative zero") with xovf=1.
- Defined: most-negative input yields saturated {1, all ones} (-(2^(bitNumber-1)-1)) with xovf=1.
- All other inputs are identical in both builds.

Test Plan:
1. Reset, then A=8'h05, B=8'hFB, in_valid 1 cycle -> out_valid rises 7 cycles after acceptance; Aout=8'h05, Bout=8'h85, Aovf=Bovf=0.
2. A=8'hFF, B=8'h81 -> Aout=8'h81, Bout=8'hFF, no ovf. Then A=8'h00, B=8'h7F -> Aout=8'h00, Bout=8'h7F.
3. A=8'h80, B=8'h80 -> Aovf=Bovf=1. Aout=Bout=8'h80 without SATURATE_EN; 8'hFF with SATURATE_EN.
4. Backpressure: out_ready low 5 cycles in DONE, new in_valid pulsed -> out_valid, Aout and Bout stable, in_ready=0, pulse ignored. out_ready high -> next cycle in_ready=1.
5. rst_n low at SHIFT bit 3 of A=8'hC3 -> outputs 0 immediately, no out_valid. After release, A=8'hC3 -> Aout=8'hBD.
6. bitNumber=4: A=4'hA, B=4'h3 -> Aout=4'hE, Bout=4'h3, out_valid 3 cycles after acceptance.
